// File: rtl/serial_load_sequencer_if.sv
// Serial-in / loader-out bus of serial_load_sequencer.
// The master drives the bit stream, and the slave (the sequencer) presents the word and the permit strobe.
interface serial_load_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             bit_in;
  logic             bit_valid;
  logic             ready;
  logic             busy;
  logic [1:WIDTH]   values;
  logic             permit;
  logic             done;
  logic             frame_err;

  modport master (
    output start, bit_in, bit_valid,
    input  ready, busy, values, permit, done, frame_err
  );

  modport slave (
    input  start, bit_in, bit_valid,
    output ready, busy, values, permit, done, frame_err
  );
endinterface

// File: rtl/serial_load_sequencer.sv
// Shifts a WIDTH-bit serial word in, then holds it on values with a PERMIT_CYCLES-long permit strobe.
//   state    | meaning
//   ST_IDLE  | waiting for start, bit_valid ignored
//   ST_SHIFT | collecting bits, start restarts the frame with frame_err
//   ST_LOAD  | permit high, values frozen, permit_cnt counts down to 0
module serial_load_sequencer #(
  parameter int WIDTH         = 16,
  parameter int PERMIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_load_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = $clog2(PERMIT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  logic [1:0]     state;
  logic [CW-1:0]  bit_cnt;
  logic [PW-1:0]  permit_cnt;
  logic [1:WIDTH] shift_q;
  logic [1:WIDTH] shift_merged;
  logic [1:WIDTH] values_q;
  logic           permit_q;
  logic           done_q;
  logic           frame_err_q;
  logic           last_bit;

  // Shift register with the incoming bit written at position bit_cnt+1.
  always_comb begin
    shift_merged = shift_q;
    for (int i = 1; i <= WIDTH; i++) begin
      if (bit_cnt == CW'(i - 1)) shift_merged[i] = bus.bit_in;
    end
  end

  assign last_bit = (bit_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      permit_cnt  <= '0;
      shift_q     <= '0;
      values_q    <= '0;
      permit_q    <= 1'b0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
            shift_q <= '0;
          end
        end
        ST_SHIFT: begin
          if (bus.start) begin
            frame_err_q <= 1'b1;
            bit_cnt     <= '0;
            shift_q     <= '0;
          end else if (bus.bit_valid) begin
            shift_q <= shift_merged;
            bit_cnt <= bit_cnt + 1'b1;
            if (last_bit) begin
              state      <= ST_LOAD;
              values_q   <= shift_merged;
              permit_q   <= 1'b1;
              done_q     <= (PERMIT_CYCLES == 1);
              permit_cnt <= PW'(PERMIT_CYCLES - 1);
            end
          end
        end
        ST_LOAD: begin
          // Terminal count: this cycle was the last permit cycle.
          if (permit_cnt == '0) begin
            permit_q <= 1'b0;
            done_q   <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            permit_cnt <= permit_cnt - 1'b1;
            done_q     <= (permit_cnt == PW'(1));
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready     = (state == ST_IDLE) & ~rst;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.values    = values_q;
  assign bus.permit    = permit_q;
  assign bus.done      = done_q;
  assign bus.frame_err = frame_err_q;
endmodule
